// File: rtl/jam_cost_table.sv
// jam_cost_table: front end that loads the 8x8 worker/job cost matrix for the
// assignment engine. It keeps the engine in reset until all 64 costs are
// stored, then serves combinational cost lookups while the engine runs, and
// parks once the engine reports completion.
//
// state | meaning
// ------+---------------------------------------------------------------
// LOAD  | accepting cost beats (row-major), engine held in reset
// ARM   | matrix complete, one settling cycle before releasing the engine
// RUN   | engine out of reset, lookups valid, waiting for jam_valid
// DONE  | engine finished, engine back in reset, waiting for clear
module jam_cost_table (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_data,
  input  logic        clear,
  input  logic [2:0]  W,
  input  logic [2:0]  J,
  output logic [6:0]  Cost,
  output logic        jam_rst,
  input  logic        jam_valid,
  output logic        loaded,
  output logic        done,
  output logic [12:0] total
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state;
  logic [5:0] cnt;
  logic [6:0] mem [0:63];
  logic       beat_accept;

  // in_ready is a registered copy of (state == LOAD), so it doubles as the
  // accept qualifier without adding a combinational path from the inputs.
  assign beat_accept = in_valid & in_ready & ~clear;

  // Sequencer: state, beat counter, running total and all registered outputs.
  // clear is checked first so it wins over a same-edge beat or jam_valid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_LOAD;
      cnt      <= 6'd0;
      total    <= 13'd0;
      in_ready <= 1'b1;
      jam_rst  <= 1'b1;
      loaded   <= 1'b0;
      done     <= 1'b0;
    end else if (clear) begin
      state    <= S_LOAD;
      cnt      <= 6'd0;
      total    <= 13'd0;
      in_ready <= 1'b1;
      jam_rst  <= 1'b1;
      loaded   <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (beat_accept) begin
            cnt   <= cnt + 6'd1;
            total <= total + {6'd0, in_data};
            if (cnt == 6'd63) begin
              state    <= S_ARM;
              in_ready <= 1'b0;
            end
          end
        end
        S_ARM: begin
          state   <= S_RUN;
          jam_rst <= 1'b0;
          loaded  <= 1'b1;
        end
        S_RUN: begin
          if (jam_valid) begin
            state   <= S_DONE;
            jam_rst <= 1'b1;
            loaded  <= 1'b0;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state    <= S_LOAD;
          cnt      <= 6'd0;
          total    <= 13'd0;
          in_ready <= 1'b1;
          jam_rst  <= 1'b1;
          loaded   <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Cost storage: written only by accepted load beats; clear leaves it intact.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 64; i++) begin
        mem[i] <= 7'd0;
      end
    end else if (beat_accept) begin
      mem[cnt] <= in_data;
    end
  end

  // Engine lookup path has no register stage.
  assign Cost = mem[{W, J}];

endmodule

// File: tb/tb_jam_cost_table.sv
// Directed testbench for jam_cost_table. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point, away from the edge.
module tb_jam_cost_table;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_data;
  logic        clear;
  logic [2:0]  W;
  logic [2:0]  J;
  logic [6:0]  Cost;
  logic        jam_rst;
  logic        jam_valid;
  logic        loaded;
  logic        done;
  logic [12:0] total;

  int n_total;
  int n_bad;

  jam_cost_table dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .clear     (clear),
    .W         (W),
    .J         (J),
    .Cost      (Cost),
    .jam_rst   (jam_rst),
    .jam_valid (jam_valid),
    .loaded    (loaded),
    .done      (done),
    .total     (total)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [6:0] beat_val(input int kind, input int idx);
    case (kind)
      0:       return 7'(idx % 128);
      1:       return 7'd127;
      2:       return 7'd5;
      default: return 7'd1;
    endcase
  endfunction

  // Streams n beats; returns how many were accepted (bounded by a cycle budget).
  task automatic load_beats(input int n, input int kind, input bit gaps, output int acc);
    int  cyc;
    logic rdy;
    cyc = 0;
    acc = 0;
    while (acc < n && cyc < 1000) begin
      in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      in_data  = beat_val(kind, acc);
      rdy      = in_ready;
      tick();
      if (in_valid && rdy) acc++;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #20;
    n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_total++; if (jam_rst !== 1'b1) begin n_bad++; $display("FAIL reset_jam_rst got=%b want=1", jam_rst); end
    n_total++; if (loaded !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_flags got=%b%b want=00", loaded, done); end
    n_total++; if (total !== 13'd0) begin n_bad++; $display("FAIL reset_total got=%0d want=0", total); end
    W = 3'd3; J = 3'd5; #1;
    n_total++; if (Cost !== 7'd0) begin n_bad++; $display("FAIL reset_cost got=%0d want=0", Cost); end
    @(negedge CLK);
    RST = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int acc;
    load_beats(64, 0, 1'b0, acc);
    n_total++; if (acc !== 64) begin n_bad++; $display("FAIL b2b_accepts got=%0d want=64", acc); end
    n_total++; if (in_ready !== 1'b0 || jam_rst !== 1'b1 || loaded !== 1'b0) begin n_bad++;
      $display("FAIL b2b_arm got=rdy%b rst%b ld%b want=rdy0 rst1 ld0", in_ready, jam_rst, loaded); end
    n_total++; if (total !== 13'd2016) begin n_bad++; $display("FAIL b2b_total_arm got=%0d want=2016", total); end
    tick();
    n_total++; if (jam_rst !== 1'b0 || loaded !== 1'b1) begin n_bad++;
      $display("FAIL b2b_run got=rst%b ld%b want=rst0 ld1", jam_rst, loaded); end
    W = 3'd3; J = 3'd5; #1;
    n_total++; if (Cost !== 7'd29) begin n_bad++; $display("FAIL b2b_cost35 got=%0d want=29", Cost); end
    W = 3'd7; J = 3'd7; #1;
    n_total++; if (Cost !== 7'd63) begin n_bad++; $display("FAIL b2b_cost77 got=%0d want=63", Cost); end
    W = 3'd1; J = 3'd0; #1;
    n_total++; if (Cost !== 7'd8) begin n_bad++; $display("FAIL b2b_cost10 got=%0d want=8", Cost); end
    tick();
  endtask

  task automatic test_gapped();
    int acc;
    pulse_clear();
    n_total++; if (in_ready !== 1'b1 || total !== 13'd0 || loaded !== 1'b0) begin n_bad++;
      $display("FAIL gap_clear got=rdy%b tot%0d ld%b want=rdy1 tot0 ld0", in_ready, total, loaded); end
    load_beats(64, 0, 1'b1, acc);
    n_total++; if (acc !== 64) begin n_bad++; $display("FAIL gap_accepts got=%0d want=64", acc); end
    in_valid = 1'b1; in_data = 7'd99;
    n_total++; if (jam_rst !== 1'b1 || in_ready !== 1'b0) begin n_bad++;
      $display("FAIL gap_arm got=rst%b rdy%b want=rst1 rdy0", jam_rst, in_ready); end
    tick();
    n_total++; if (jam_rst !== 1'b0) begin n_bad++; $display("FAIL gap_jam_rst_fall got=%b want=0", jam_rst); end
    tick(); tick(); tick();
    in_valid = 1'b0;
    W = 3'd0; J = 3'd0; #1;
    n_total++; if (Cost !== 7'd0) begin n_bad++; $display("FAIL gap_mem0 got=%0d want=0", Cost); end
    n_total++; if (total !== 13'd2016) begin n_bad++; $display("FAIL gap_total got=%0d want=2016", total); end
    tick();
  endtask

  task automatic test_jam_done();
    jam_valid = 1'b1;
    tick();
    jam_valid = 1'b0;
    n_total++; if (done !== 1'b1 || jam_rst !== 1'b1 || loaded !== 1'b0) begin n_bad++;
      $display("FAIL jam_done got=dn%b rst%b ld%b want=dn1 rst1 ld0", done, jam_rst, loaded); end
    tick();
    jam_valid = 1'b1;
    tick();
    jam_valid = 1'b0;
    tick();
    n_total++; if (done !== 1'b1 || jam_rst !== 1'b1 || in_ready !== 1'b0 || total !== 13'd2016) begin n_bad++;
      $display("FAIL jam_second got=dn%b rst%b rdy%b tot%0d want=dn1 rst1 rdy0 tot2016", done, jam_rst, in_ready, total); end
  endtask

  task automatic test_clear_reload();
    int acc;
    int wrong;
    pulse_clear();
    n_total++; if (in_ready !== 1'b1 || done !== 1'b0) begin n_bad++;
      $display("FAIL clr_state got=rdy%b dn%b want=rdy1 dn0", in_ready, done); end
    W = 3'd3; J = 3'd5; #1;
    n_total++; if (Cost !== 7'd29) begin n_bad++; $display("FAIL clr_mem_kept got=%0d want=29", Cost); end
    load_beats(30, 2, 1'b0, acc);
    n_total++; if (total !== 13'd150) begin n_bad++; $display("FAIL clr_partial_total got=%0d want=150", total); end
    pulse_clear();
    n_total++; if (total !== 13'd0) begin n_bad++; $display("FAIL clr_total_zero got=%0d want=0", total); end
    load_beats(64, 1, 1'b0, acc);
    tick();
    n_total++; if (total !== 13'd8128 || loaded !== 1'b1) begin n_bad++;
      $display("FAIL clr_full_total got=%0d ld%b want=8128 ld1", total, loaded); end
    wrong = 0;
    for (int a = 0; a < 64; a++) begin
      W = 3'(a / 8); J = 3'(a % 8); #1;
      if (Cost !== 7'd127) wrong++;
    end
    n_total++; if (wrong !== 0) begin n_bad++; $display("FAIL clr_all127 got=%0d_bad_entries want=0", wrong); end
    tick();
  endtask

  task automatic test_clear_beat();
    pulse_clear();
    in_valid = 1'b1; in_data = 7'd55; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    W = 3'd0; J = 3'd0; #1;
    n_total++; if (total !== 13'd0 || Cost !== 7'd127) begin n_bad++;
      $display("FAIL cb_discard got=tot%0d cost%0d want=tot0 cost127", total, Cost); end
    in_valid = 1'b1; in_data = 7'd11;
    tick();
    in_valid = 1'b0;
    W = 3'd0; J = 3'd0; #1;
    n_total++; if (Cost !== 7'd11 || total !== 13'd11) begin n_bad++;
      $display("FAIL cb_addr0 got=cost%0d tot%0d want=cost11 tot11", Cost, total); end
    W = 3'd0; J = 3'd1; #1;
    n_total++; if (Cost !== 7'd127) begin n_bad++; $display("FAIL cb_addr1 got=%0d want=127", Cost); end
    tick();
  endtask

  task automatic test_async_rst();
    int acc;
    pulse_clear();
    load_beats(64, 3, 1'b0, acc);
    tick();
    n_total++; if (loaded !== 1'b1 || total !== 13'd64) begin n_bad++;
      $display("FAIL ar_run got=ld%b tot%0d want=ld1 tot64", loaded, total); end
    #3;
    RST = 1'b1;
    #1;
    n_total++; if (jam_rst !== 1'b1 || in_ready !== 1'b1 || loaded !== 1'b0 || total !== 13'd0) begin n_bad++;
      $display("FAIL ar_immediate got=rst%b rdy%b ld%b tot%0d want=rst1 rdy1 ld0 tot0", jam_rst, in_ready, loaded, total); end
    W = 3'd3; J = 3'd5; #0.5;
    n_total++; if (Cost !== 7'd0) begin n_bad++; $display("FAIL ar_cost35 got=%0d want=0", Cost); end
    W = 3'd7; J = 3'd7; #0.5;
    n_total++; if (Cost !== 7'd0) begin n_bad++; $display("FAIL ar_cost77 got=%0d want=0", Cost); end
    @(negedge CLK);
    RST = 1'b0;
    tick();
    load_beats(64, 0, 1'b0, acc);
    tick();
    W = 3'd3; J = 3'd5; #1;
    n_total++; if (loaded !== 1'b1 || jam_rst !== 1'b0 || total !== 13'd2016 || Cost !== 7'd29) begin n_bad++;
      $display("FAIL ar_reload got=ld%b rst%b tot%0d cost%0d want=ld1 rst0 tot2016 cost29", loaded, jam_rst, total, Cost); end
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    RST       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 7'd0;
    clear     = 1'b0;
    W         = 3'd0;
    J         = 3'd0;
    jam_valid = 1'b0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_jam_done();
    test_clear_reload();
    test_clear_beat();
    test_async_rst();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
